muldiv_seq: RTL and testbench

Multi-cycle sequencer for the RV32IM M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) beside the single-cycle core's ALU. It latches operands when the decoder flags an M instruction and runs an iterative shift-add multiplier or restoring divider. While it works, it raises `stall`, which freezes the PC register and masks the register-file write enable. Its result enters the datapath's result mux on the single cycle the instruction retires.

---
 rtl/muldiv_seq.sv | 133 +++++++++++++
 tb/tb_muldiv_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M multiply/divide sequencer (shift-add multiply, restoring divide).
// Optional macro MULDIV_FAST_MUL_EN: the MUL ops use a single combinational multiply and finish in 2 cycles.
module muldiv_seq #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req,
   input  logic [2:0]            funct3,
   input  logic [DATA_WIDTH-1:0] src_a,
   input  logic [DATA_WIDTH-1:0] src_b,
   output logic                  stall,
   output logic                  valid,
   output logic                  busy,
   output logic [DATA_WIDTH-1:0] result
);
   localparam int W = DATA_WIDTH;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state;
   logic [4:0] cnt;
   logic [2:0] op;
   logic neg;
   logic [W-1:0] hi, lo, dvs;
   logic a_sgn, b_sgn, a_neg, b_neg, b_zero, special;
   logic [W-1:0] a_mag, b_mag, spec_res, n_hi, n_lo, fin;
   logic [W:0] shl, dif;
`ifdef MULDIV_FAST_MUL_EN
   logic signed [2*W+1:0] fprod;
`else
   logic [W:0] sum;
   logic [2*W-1:0] p_fix;
`endif

   // Operand magnitudes and early-completion results for the op being issued
   always_comb begin
      a_sgn = !(funct3[0] & (funct3[1] | funct3[2]));
      b_sgn = funct3[2] ? !funct3[0] : !funct3[1];
      a_neg = a_sgn & src_a[W-1];
      b_neg = b_sgn & src_b[W-1];
      a_mag = a_neg ? -src_a : src_a;
      b_mag = b_neg ? -src_b : src_b;
      b_zero = (src_b == '0);
`ifdef MULDIV_FAST_MUL_EN
      fprod = $signed({a_sgn & src_a[W-1], src_a}) * $signed({b_sgn & src_b[W-1], src_b});
      special = !funct3[2] | b_zero | (!funct3[0] & (src_a == {1'b1, {(W-1){1'b0}}}) & (src_b == '1));
      spec_res = !funct3[2] ? (funct3[1:0] == 2'b00 ? fprod[W-1:0] : fprod[2*W-1:W])
               : b_zero ? (funct3[1] ? src_a : '1) : (funct3[1] ? '0 : src_a);
`else
      special = funct3[2] & (b_zero | (!funct3[0] & (src_a == {1'b1, {(W-1){1'b0}}}) & (src_b == '1)));
      spec_res = b_zero ? (funct3[1] ? src_a : '1) : (funct3[1] ? '0 : src_a);
`endif
   end

   // One iteration on the latched operands, and the sign-corrected value it would retire with
   always_comb begin
      shl = {hi, lo[W-1]};
      dif = shl - {1'b0, dvs};
`ifdef MULDIV_FAST_MUL_EN
      n_hi = !dif[W] ? dif[W-1:0] : shl[W-1:0];
      n_lo = {lo[W-2:0], !dif[W]};
      fin = op[1] ? (neg ? -n_hi : n_hi) : (neg ? -n_lo : n_lo);
`else
      sum = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
      n_hi = op[2] ? (!dif[W] ? dif[W-1:0] : shl[W-1:0]) : sum[W:1];
      n_lo = op[2] ? {lo[W-2:0], !dif[W]} : {sum[0], lo[W-1:1]};
      p_fix = neg ? -{n_hi, n_lo} : {n_hi, n_lo};
      fin = op[2] ? (op[1] ? (neg ? -n_hi : n_hi) : (neg ? -n_lo : n_lo))
          : (op[1:0] == 2'b00 ? p_fix[W-1:0] : p_fix[2*W-1:W]);
`endif
   end

   // Stall the core while an M op is pending; reset overrides a held request
   assign stall = reset & ((state == BUSY) | ((state == IDLE) & req));

   // Sequencer: latch on request, iterate 32 times, retire for one cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt <= '0;
         op <= '0;
         neg <= 1'b0;
         hi <= '0;
         lo <= '0;
         dvs <= '0;
         valid <= 1'b0;
         busy <= 1'b0;
         result <= '0;
      end else begin
         case (state)
            IDLE: begin
               valid <= 1'b0;
               if (req) begin
                  op <= funct3;
                  neg <= (funct3[2] & funct3[1]) ? a_neg : a_neg ^ b_neg;
                  hi <= '0;
                  lo <= a_mag;
                  dvs <= b_mag;
                  cnt <= 5'd31;
                  if (special) begin
                     state <= DONE;
                     valid <= 1'b1;
                     result <= spec_res;
                  end else begin
                     state <= BUSY;
                     busy <= 1'b1;
                  end
               end
            end
            BUSY: begin
               if (!req) begin
                  state <= IDLE;
                  busy <= 1'b0;
               end else begin
                  hi <= n_hi;
                  lo <= n_lo;
                  cnt <= cnt - 5'd1;
                  if (cnt == 5'd0) begin
                     state <= DONE;
                     busy <= 1'b0;
                     valid <= 1'b1;
                     result <= fin;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               valid <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: randomized self-checking bench for muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;
   logic clk = 1'b0, reset = 1'b0, req = 1'b0;
   logic [2:0] funct3 = '0;
   logic [31:0] src_a = '0, src_b = '0;
   logic stall, valid, busy;
   logic [31:0] result;
   int checks = 0, passed = 0;
`ifdef MULDIV_FAST_MUL_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   muldiv_seq #(.DATA_WIDTH(32)) dut (.clk(clk), .reset(reset), .req(req), .funct3(funct3),
      .src_a(src_a), .src_b(src_b), .stall(stall), .valid(valid), .busy(busy), .result(result));

   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ub;
      logic [63:0] ua, p;
      sa = $signed(a);
      sb = $signed(b);
      ub = longint'({32'b0, b});
      ua = {32'b0, a};
      case (f)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * {32'b0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFFFFFF;
            p = sa / sb;
            return p[31:0];
         end
         3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            p = sa % sb;
            return p[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
      if (FAST && !f[2]) return 1;
      return 33;
   endfunction

   // Issue one op and report the retire cycle, result and any stall irregularity; scrambles inputs once latched
   task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output int stall_err);
      lat = -1;
      res = 'x;
      stall_err = 0;
      @(posedge clk); #1;
      req = 1'b1; funct3 = f; src_a = a; src_b = b;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (valid) begin
            lat = c;
            res = result;
            if (stall) stall_err++;
            break;
         end
         if (!stall) stall_err++;
         if (c >= 1) begin
            funct3 = 3'($urandom);
            src_a = $urandom;
            src_b = $urandom;
         end
      end
      @(posedge clk); #1;
      req = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall); else passed++;
      checks++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
      checks++; if (result !== 32'h0) $display("FAIL reset_result: got %h expected 0", result); else passed++;
      reset = 1'b1;
   endtask

   task automatic test_mul_basic();
      int lat, se;
      logic [31:0] res;
      do_op(3'd0, 32'd7, 32'hFFFFFFFD, lat, res, se);
      checks++; if (res !== 32'hFFFFFFEB) $display("FAIL mul_basic_result: got %h expected ffffffeb", res); else passed++;
      checks++; if (lat !== exp_lat(3'd0, 32'd7, 32'hFFFFFFFD)) $display("FAIL mul_basic_latency: got %0d expected %0d", lat, exp_lat(3'd0, 32'd7, 32'hFFFFFFFD)); else passed++;
      checks++; if (se !== 0) $display("FAIL mul_basic_stall: got %0d bad cycles expected 0", se); else passed++;
   endtask

   task automatic test_vectors();
      logic [2:0] vf [11] = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
      logic [31:0] va [11] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                               32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
      logic [31:0] vb [11] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                               32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
      logic [31:0] ve [11] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                               32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
      int lat, se;
      logic [31:0] res;
      for (int i = 0; i < 11; i++) begin
         do_op(vf[i], va[i], vb[i], lat, res, se);
         checks++; if (res !== ve[i]) $display("FAIL vector%0d_result: got %h expected %h", i, res, ve[i]); else passed++;
         checks++; if (lat !== exp_lat(vf[i], va[i], vb[i])) $display("FAIL vector%0d_latency: got %0d expected %0d", i, lat, exp_lat(vf[i], va[i], vb[i])); else passed++;
      end
   endtask

   task automatic test_random();
      int lat, se;
      logic [2:0] f;
      logic [31:0] a, b, res;
      for (int i = 0; i < 30; i++) begin
         f = 3'($urandom);
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 4))
            0: b = 32'd0;
            1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            2: b = $urandom_range(1, 20);
            3: a = $urandom_range(0, 1000);
            default: ;
         endcase
         do_op(f, a, b, lat, res, se);
         checks++; if (res !== model(f, a, b)) $display("FAIL random%0d_f%0d_result: a=%h b=%h got %h expected %h", i, f, a, b, res, model(f, a, b)); else passed++;
         checks++; if (lat !== exp_lat(f, a, b)) $display("FAIL random%0d_latency: got %0d expected %0d", i, lat, exp_lat(f, a, b)); else passed++;
         checks++; if (se !== 0) $display("FAIL random%0d_stall: got %0d bad cycles expected 0", i, se); else passed++;
      end
   endtask

   task automatic test_back_to_back();
      int pulses = 0, stall_lo = 0, both = 0;
      int vcyc [2] = '{-1, -1};
      logic [31:0] vres [2] = '{32'hx, 32'hx};
      @(posedge clk); #1;
      req = 1'b1; funct3 = 3'd5; src_a = 32'd9; src_b = 32'd3;
      for (int c = 0; c < 120; c++) begin
         @(negedge clk);
         if (stall && valid) both++;
         if (req && !stall) stall_lo++;
         if (valid) begin
            if (pulses < 2) begin vcyc[pulses] = c; vres[pulses] = result; end
            pulses++;
            if (pulses == 1) begin funct3 = 3'd0; src_a = 32'd3; src_b = 32'd4; end
            else req = 1'b0;
         end
      end
      req = 1'b0;
      checks++; if (pulses !== 2) $display("FAIL b2b_pulses: got %0d expected 2", pulses); else passed++;
      checks++; if (vres[0] !== 32'd3) $display("FAIL b2b_first_result: got %h expected 3", vres[0]); else passed++;
      checks++; if (vres[1] !== 32'd12) $display("FAIL b2b_second_result: got %h expected c", vres[1]); else passed++;
      checks++; if (vcyc[0] !== 33) $display("FAIL b2b_first_cycle: got %0d expected 33", vcyc[0]); else passed++;
      checks++; if (vcyc[1] !== 34 + exp_lat(3'd0, 32'd3, 32'd4)) $display("FAIL b2b_second_cycle: got %0d expected %0d", vcyc[1], 34 + exp_lat(3'd0, 32'd3, 32'd4)); else passed++;
      checks++; if (stall_lo !== 2) $display("FAIL b2b_stall_low: got %0d expected 2", stall_lo); else passed++;
      checks++; if (both !== 0) $display("FAIL b2b_stall_and_valid: got %0d expected 0", both); else passed++;
   endtask

   task automatic test_reset_abort();
      int lat, se;
      logic [31:0] res;
      @(posedge clk); #1;
      req = 1'b1; funct3 = 3'd4; src_a = $urandom; src_b = $urandom | 32'd1;
      repeat (11) @(negedge clk);
      checks++; if (busy !== 1'b1) $display("FAIL reset_mid_busy_before: got %b expected 1", busy); else passed++;
      reset = 1'b0;
      #1;
      checks++; if (stall !== 1'b0) $display("FAIL reset_mid_stall: got %b expected 0", stall); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_mid_busy: got %b expected 0", busy); else passed++;
      checks++; if (valid !== 1'b0) $display("FAIL reset_mid_valid: got %b expected 0", valid); else passed++;
      checks++; if (result !== 32'h0) $display("FAIL reset_mid_result: got %h expected 0", result); else passed++;
      @(negedge clk);
      req = 1'b0;
      reset = 1'b1;
      do_op(3'd4, 32'd20, 32'd4, lat, res, se);
      checks++; if (res !== 32'd5) $display("FAIL after_reset_div_result: got %h expected 5", res); else passed++;
      checks++; if (lat !== 33) $display("FAIL after_reset_div_latency: got %0d expected 33", lat); else passed++;
   endtask

   task automatic test_abort();
      int vcount = 0;
      @(posedge clk); #1;
      req = 1'b1; funct3 = 3'd7; src_a = $urandom | 32'd1; src_b = $urandom_range(1, 1000);
      repeat (6) @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else passed++;
      checks++; if (stall !== 1'b0) $display("FAIL abort_stall: got %b expected 0", stall); else passed++;
      for (int c = 0; c < 40; c++) begin
         if (valid) vcount++;
         @(negedge clk);
      end
      checks++; if (vcount !== 0) $display("FAIL abort_valid_pulses: got %0d expected 0", vcount); else passed++;
   endtask

   initial begin
      test_reset();
      test_mul_basic();
      test_vectors();
      test_random();
      test_back_to_back();
      test_reset_abort();
      test_abort();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
